jstk_spi_responder: RTL and testbench

SPI slave that emulates the PmodJSTK joystick module at the far end of the joystick SPI link. It sits opposite the joystick SPI master (`JoystickPosition`), either in simulation benches or on a second Pmod port for loopback bring-up. It answers each 5-byte frame with a snapshot of the supplied X/Y/button values. It also decodes the master's LED command byte.

---
 rtl/jstk_pkg.sv | 17 +
 rtl/jstk_spi_responder_sync_edge.sv | 49 ++++
 rtl/jstk_spi_responder.sv | 178 +++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI responder.
//   JSTK_FRAME_BYTES : bytes per joystick frame (BYTE_IDX saturates here)
//   JSTK_CMD_LED_BIT : bit of byte0 that marks an LED command
//   JSTK_LED_MASK    : LED bits taken from the command byte
//   jstk_state_e     : responder FSM states
package jstk_pkg;

  localparam int         JSTK_FRAME_BYTES = 5;
  localparam int         JSTK_CMD_LED_BIT = 7;
  localparam logic [1:0] JSTK_LED_MASK    = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } jstk_state_e;

endpackage

// File: rtl/jstk_spi_responder_sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous level with registered
// rise/fall pulses.
//   clk  : system clock
//   rst  : synchronous active-high reset (stages clear to 0)
//   d    : asynchronous input
//   rise : one-cycle pulse, input seen going 0 -> 1
//   fall : one-cycle pulse, input seen going 1 -> 0
// The pulse flops act as the second synchronizer stage, so a pulse is
// visible two CLK after the raw change and consumed on the third edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end

  // Clearing to 0 means a low input held through reset produces no fall
  // pulse; a fresh falling edge is needed after the line has been high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave emulating a PmodJSTK. Each 5-byte
// frame returns X/Y/BTN snapshotted at SS fall; byte0 from the master can
// carry an LED command.
//   CLK, RST       : system clock, synchronous active-high reset
//   SS, SCLK, MOSI : SPI from master (asynchronous to CLK)
//   MISO           : responder data, MSB first, 0 when idle
//   X, Y, BTN      : joystick values to report
//   LED            : LED state commanded by the master
//   FRAME_DONE     : one-CLK pulse after a complete 40-bit frame
//   BYTE_IDX       : byte being shifted, 0..5 (5 = overrun)
// Optional feature macro: JSTK_RESP_LED_EN enables the MOSI receive path and
// the LED command decoder; without it LED is tied to 2'b00.
//
// state | meaning
// IDLE  | SS high (or waiting for a fresh SS fall after reset), MISO = 0
// SHIFT | frame in progress; BYTE_IDX = 5 marks overrun after bit 39
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int CLK_DIV_MIN = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic [2:0] BTN,
  output logic [1:0] LED,
  output logic       FRAME_DONE,
  output logic [2:0] BYTE_IDX
);

  logic ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;

  sync_edge u_ss_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (SS),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge u_sclk_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  jstk_state_e state_q, state_d;
  logic [39:0] tx_q, tx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  phase_q, phase_d;

`ifdef JSTK_RESP_LED_EN
  logic       mosi_s1_q, mosi_s2_q;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_byte;
  logic [1:0] led_q, led_d;
`else
  logic unused_mosi;
  assign unused_mosi = MOSI;
`endif

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    frame_done_d = 1'b0;
`ifdef JSTK_RESP_LED_EN
    rx_d    = rx_q;
    led_d   = led_q;
    rx_byte = {rx_q[6:0], mosi_s2_q};
`endif
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SHIFT;
          tx_d       = {X[7:0], 6'b0, X[9:8], Y[7:0], 6'b0, Y[9:8], 5'b0, BTN};
          bit_cnt_d  = 3'd0;
          byte_idx_d = 3'd0;
        end
      end
      SHIFT: begin
        // Zero fill means overrun bits read back as 0 with no extra logic.
        if (sclk_fall) tx_d = {tx_q[38:0], 1'b0};
        if (sclk_rise && (byte_idx_q < 3'(JSTK_FRAME_BYTES))) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef JSTK_RESP_LED_EN
          rx_d = rx_byte;
`endif
          if (bit_cnt_q == 3'd7) begin
            byte_idx_d = byte_idx_q + 3'd1;
            if (byte_idx_q == 3'(JSTK_FRAME_BYTES - 1)) frame_done_d = 1'b1;
`ifdef JSTK_RESP_LED_EN
            if ((byte_idx_q == 3'd0) && rx_byte[JSTK_CMD_LED_BIT])
              led_d = rx_byte[1:0] & JSTK_LED_MASK;
`endif
          end
        end
        // Evaluated last so a final rise coincident with SS rise still
        // reports the frame before returning to IDLE.
        if (ss_rise) begin
          state_d    = IDLE;
          tx_d       = '0;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      bit_cnt_q    <= 3'd0;
      byte_idx_q   <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef JSTK_RESP_LED_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      rx_q      <= '0;
      led_q     <= 2'b00;
    end else begin
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
      rx_q      <= rx_d;
      led_q     <= led_d;
    end
  end
  assign LED = led_q;
`else
  assign LED = 2'b00;
`endif

  assign MISO       = (state_q == SHIFT) ? tx_q[39] : 1'b0;
  assign FRAME_DONE = frame_done_q;
  assign BYTE_IDX   = byte_idx_q;

  // CLK cycles since the last synchronized SCLK edge, saturating; only
  // feeds the SCLK phase-width check below.
  always_comb begin
    phase_d = phase_q;
    if (sclk_rise || sclk_fall) phase_d = 8'd0;
    else if (phase_q != 8'hFF) phase_d = phase_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) phase_q <= 8'hFF;
    else     phase_q <= phase_d;
  end

  // One CLK of slack for synchronizer sampling jitter.
  a_sclk_phase : assert property (@(posedge CLK) disable iff (RST)
    (sclk_rise || sclk_fall) |-> (phase_q >= 8'(CLK_DIV_MIN / 2 - 1)));

endmodule

// File: tb/tb_jstk_spi_responder.sv
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi;
  logic       miso;
  logic [9:0] x, y;
  logic [2:0] btn;
  logic [1:0] led;
  logic       frame_done;
  logic [2:0] byte_idx;

  always #5 clk = ~clk;

  jstk_spi_responder #(.CLK_DIV_MIN(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SS         (ss),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .X          (x),
    .Y          (y),
    .BTN        (btn),
    .LED        (led),
    .FRAME_DONE (frame_done),
    .BYTE_IDX   (byte_idx)
  );

`ifdef JSTK_RESP_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  logic [1:0] model_led = 2'b00;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master transaction of nbits SCLK cycles at CLK/20. rst_at / x_change_at
  // give the bit index at which to pulse RST / change X (-1 = never).
  task automatic spi_frame(input int nbits, input logic [7:0] cmd0,
                           input int rst_at, input int x_change_at);
    logic [39:0] exp_frame;
    int fd0;
    bit active;
    int nb;
    exp_frame[39:32] = 8'(x % 256);
    exp_frame[31:24] = 8'(x / 256);
    exp_frame[23:16] = 8'(y % 256);
    exp_frame[15:8]  = 8'(y / 256);
    exp_frame[7:0]   = 8'(btn);
    fd0    = fd_cnt;
    active = 1'b1;
    ss = 1'b0;
    wait_clk(6);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        active = 1'b0;
        model_led = 2'b00;
        wait_clk(1);
        check_val("rst_miso", 64'(miso), 64'd0);
        check_val("rst_led", 64'(led), 64'd0);
        check_val("rst_frame_done", 64'(frame_done), 64'd0);
        check_val("rst_byte_idx", 64'(byte_idx), 64'd0);
      end
      if (k == x_change_at) x = 10'h3FF;
      mosi = (k < 8) ? cmd0[7-k] : 1'($urandom);
      wait_clk(10);
      check_val($sformatf("miso_bit%0d", k), 64'(miso),
                (active && k < 40) ? 64'(exp_frame[39-k]) : 64'd0);
      sclk = 1'b1;
      wait_clk(5);
      if (active && k == 7 && cmd0[7] && LED_EN) model_led = cmd0[1:0];
      nb = (k + 1) / 8;
      if (nb > 5) nb = 5;
      check_val($sformatf("byte_idx_bit%0d", k), 64'(byte_idx), active ? 64'(nb) : 64'd0);
      check_val($sformatf("led_bit%0d", k), 64'(led), 64'(model_led));
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(10);
    check_val("frame_done_count", 64'(fd_cnt - fd0), (active && nbits >= 40) ? 64'd1 : 64'd0);
    ss = 1'b1;
    wait_clk(6);
    check_val("idle_byte_idx", 64'(byte_idx), 64'd0);
    check_val("idle_miso", 64'(miso), 64'd0);
    check_val("idle_led", 64'(led), 64'(model_led));
    wait_clk(4);
  endtask

  initial begin
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x = 10'h2A5; y = 10'h1C3; btn = 3'b101;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(4);
    check_val("reset_miso", 64'(miso), 64'd0);
    check_val("reset_led", 64'(led), 64'd0);
    check_val("reset_frame_done", 64'(frame_done), 64'd0);
    check_val("reset_byte_idx", 64'(byte_idx), 64'd0);

    // A5 02 C3 01 05
    spi_frame(40, 8'h00, -1, -1);
    // LED command, then a non-command byte0 must leave LED alone
    spi_frame(40, 8'h82, -1, -1);
    spi_frame(40, 8'h00, -1, -1);
    // X changes after SS fall: snapshot holds, next frame shows FF 03
    spi_frame(40, 8'h00, -1, 5);
    spi_frame(40, 8'h00, -1, -1);
    // abort after 17 bits, then a clean frame
    x = 10'h155; y = 10'h2AA; btn = 3'b010;
    spi_frame(17, 8'h81, -1, -1);
    spi_frame(40, 8'h00, -1, -1);
    // overrun
    spi_frame(48, 8'h83, -1, -1);
    // reset at bit 12 with SS held low, then recover
    spi_frame(40, 8'h81, 12, -1);
    spi_frame(40, 8'h00, -1, -1);

    for (int i = 0; i < 10; i++) begin
      int nbits;
      logic [7:0] cmd;
      x   = 10'($urandom_range(0, 1023));
      y   = 10'($urandom_range(0, 1023));
      btn = 3'($urandom_range(0, 7));
      cmd = 8'($urandom_range(0, 255));
      nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 48)) : 40;
      spi_frame(nbits, cmd, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
